// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - ALU operator and bitmanip configuration types shared by the sequencer and its ALU
package ibex_pkg;

    typedef enum integer {
        RV32BNone,
        RV32BBalanced,
        RV32BOTEarlGrey,
        RV32BFull
    } rv32b_e;

    typedef enum logic [6:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_XOR,
        ALU_OR,
        ALU_AND,
        ALU_SRA,
        ALU_SRL,
        ALU_SLL,
        ALU_ROR,
        ALU_ROL,
        ALU_FSR,
        ALU_FSL,
        ALU_CMIX,
        ALU_LT,
        ALU_LTU,
        ALU_EQ,
        ALU_NE
    } alu_op_e;

endpackage

// File: rtl/ibex_alu_seq_if.sv
// rtl/ibex_alu_seq_if.sv - request/response handshake bundle between a requester and ibex_alu_seq
interface ibex_alu_seq_if;
    import ibex_pkg::*;

    logic        in_valid;
    logic        in_ready;
    alu_op_e     operator;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rs3;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    modport master (
        output in_valid, operator, rs1, rs2, rs3, kill, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, operator, rs1, rs2, rs3, kill, out_ready,
        output in_ready, out_valid, result, busy
    );

endinterface

// File: rtl/ibex_alu_seq.sv
// rtl/ibex_alu_seq.sv - one-at-a-time ALU request sequencer; splits rotate/funnel/cmix into two base-op cycles
module ibex_alu_seq
    import ibex_pkg::*;
#(
    parameter rv32b_e RV32B = RV32BNone
) (
    input  logic              clk_i,
    input  logic              rst_i,
    ibex_alu_seq_if.slave     req,
    output alu_op_e           alu_operator_o,
    output logic [31:0]       alu_operand_a_o,
    output logic [31:0]       alu_operand_b_o,
    output logic              alu_instr_first_cycle_o,
    input  logic [31:0]       alu_result_i
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC1,
        EXEC2,
        DONE
    } state_e;

    state_e      state_q, state_d;
    alu_op_e     op_q, op_d;
    logic        multi_q, multi_d;
    logic [31:0] rs1_q, rs1_d;
    logic [31:0] rs2_q, rs2_d;
    logic [31:0] rs3_q, rs3_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  n_q, n_d;
    logic [31:0] imd_q, imd_d;
    logic [31:0] result_q, result_d;

    logic        dec_multi;
    logic        dec_funnel;
    logic        dec_swap;
    logic [4:0]  m;

    // Decode is taken straight from the request so it can be latched on acceptance.
    assign dec_multi  = (RV32B != RV32BNone) &&
                        (req.operator inside {ALU_ROL, ALU_ROR, ALU_FSL, ALU_FSR, ALU_CMIX});
    assign dec_funnel = req.operator inside {ALU_FSL, ALU_FSR};
    assign dec_swap   = dec_funnel & req.rs2[5];
    assign m          = 5'd0 - n_q;

    always_comb begin
        state_d                 = state_q;
        op_d                    = op_q;
        multi_d                 = multi_q;
        rs1_d                   = rs1_q;
        rs2_d                   = rs2_q;
        rs3_d                   = rs3_q;
        a_d                     = a_q;
        b_d                     = b_q;
        n_d                     = n_q;
        imd_d                   = imd_q;
        result_d                = result_q;
        alu_operator_o          = ALU_ADD;
        alu_operand_a_o         = 32'd0;
        alu_operand_b_o         = 32'd0;
        alu_instr_first_cycle_o = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (req.in_valid && !req.kill) begin
                    op_d    = req.operator;
                    multi_d = dec_multi;
                    rs1_d   = req.rs1;
                    rs2_d   = req.rs2;
                    rs3_d   = req.rs3;
                    a_d     = dec_swap ? req.rs3 : req.rs1;
                    b_d     = !dec_funnel ? req.rs1 : (dec_swap ? req.rs1 : req.rs3);
                    n_d     = req.rs2[4:0];
                    state_d = EXEC1;
                end
            end
            EXEC1: begin
                alu_instr_first_cycle_o = 1'b1;
                if (multi_q) begin
                    unique case (op_q)
                        ALU_ROL, ALU_FSL: begin
                            alu_operator_o  = ALU_SLL;
                            alu_operand_a_o = a_q;
                            alu_operand_b_o = {27'd0, n_q};
                        end
                        ALU_ROR, ALU_FSR: begin
                            alu_operator_o  = ALU_SRL;
                            alu_operand_a_o = a_q;
                            alu_operand_b_o = {27'd0, n_q};
                        end
                        ALU_CMIX: begin
                            alu_operator_o  = ALU_AND;
                            alu_operand_a_o = rs1_q;
                            alu_operand_b_o = rs2_q;
                        end
                        default: begin
                            alu_operator_o  = ALU_ADD;
                        end
                    endcase
                    imd_d   = alu_result_i;
                    state_d = EXEC2;
                end else begin
                    alu_operator_o  = op_q;
                    alu_operand_a_o = rs1_q;
                    alu_operand_b_o = rs2_q;
                    result_d        = alu_result_i;
                    state_d         = DONE;
                end
            end
            EXEC2: begin
                alu_instr_first_cycle_o = 1'b0;
                unique case (op_q)
                    ALU_ROL, ALU_FSL: begin
                        alu_operator_o  = ALU_SRL;
                        alu_operand_a_o = b_q;
                        alu_operand_b_o = {27'd0, m};
                    end
                    ALU_ROR, ALU_FSR: begin
                        alu_operator_o  = ALU_SLL;
                        alu_operand_a_o = b_q;
                        alu_operand_b_o = {27'd0, m};
                    end
                    ALU_CMIX: begin
                        alu_operator_o  = ALU_AND;
                        alu_operand_a_o = rs3_q;
                        alu_operand_b_o = ~rs2_q;
                    end
                    default: begin
                        alu_operator_o  = ALU_ADD;
                    end
                endcase
                // A zero shift would OR B in un-shifted; the answer is just A
                // (funnel amount 0 -> rs1, amount 32 -> rs3 after the swap).
                if (op_q != ALU_CMIX && n_q == 5'd0) begin
                    result_d = a_q;
                end else begin
                    result_d = imd_q | alu_result_i;
                end
                state_d = DONE;
            end
            DONE: begin
                if (req.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q != IDLE && req.kill) begin
            state_d  = IDLE;
            imd_d    = 32'd0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            op_q     <= ALU_ADD;
            multi_q  <= 1'b0;
            rs1_q    <= 32'd0;
            rs2_q    <= 32'd0;
            rs3_q    <= 32'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            n_q      <= 5'd0;
            imd_q    <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            multi_q  <= multi_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rs3_q    <= rs3_d;
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            imd_q    <= imd_d;
            result_q <= result_d;
        end
    end

    assign req.in_ready  = (state_q == IDLE);
    assign req.out_valid = (state_q == DONE);
    assign req.result    = result_q;
    assign req.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ibex_alu_seq.sv
// tb/tb_ibex_alu_seq.sv - directed bench for ibex_alu_seq with a behavioural ALU on the operator side
module tb_ibex_alu_seq;
    import ibex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    alu_op_e     alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_first;
    logic [31:0] alu_res;

    int          checks   = 0;
    int          failures = 0;
    int          lat;
    logic        c1_first;
    logic        c2_first;
    logic [31:0] c2_opb;

    always #5 clk = ~clk;

    ibex_alu_seq_if bus ();

    ibex_alu_seq #(.RV32B(RV32BFull)) dut (
        .clk_i                   (clk),
        .rst_i                   (rst),
        .req                     (bus.slave),
        .alu_operator_o          (alu_op),
        .alu_operand_a_o         (alu_a),
        .alu_operand_b_o         (alu_b),
        .alu_instr_first_cycle_o (alu_first),
        .alu_result_i            (alu_res)
    );

    always_comb begin
        alu_res = 32'd0;
        case (alu_op)
            ALU_ADD: alu_res = alu_a + alu_b;
            ALU_SUB: alu_res = alu_a - alu_b;
            ALU_XOR: alu_res = alu_a ^ alu_b;
            ALU_OR:  alu_res = alu_a | alu_b;
            ALU_AND: alu_res = alu_a & alu_b;
            ALU_SLL: alu_res = alu_a << alu_b[4:0];
            ALU_SRL: alu_res = alu_a >> alu_b[4:0];
            ALU_SRA: alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            ALU_LT:  alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_LTU: alu_res = {31'd0, alu_a < alu_b};
            ALU_EQ:  alu_res = {31'd0, alu_a == alu_b};
            ALU_NE:  alu_res = {31'd0, alu_a != alu_b};
            default: alu_res = 32'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input alu_op_e op, input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] r3);
        bus.in_valid = 1'b1;
        bus.operator = op;
        bus.rs1      = r1;
        bus.rs2      = r2;
        bus.rs3      = r3;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input alu_op_e op, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] r3,
                          input logic [31:0] exp_res, input int exp_lat);
        bus.out_ready = 1'b1;
        check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        issue(op, r1, r2, r3);
        lat      = 1;
        c1_first = alu_first;
        while (!bus.out_valid && lat < 10) begin
            step();
            lat++;
            if (lat == 2) begin
                c2_opb   = alu_b;
                c2_first = alu_first;
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, bus.result, exp_res);
        step();
        check({tag, "_pulse"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.operator  = ALU_ADD;
        bus.rs1       = 32'd0;
        bus.rs2       = 32'd0;
        bus.rs3       = 32'd0;
        bus.kill      = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_alu_op", {25'd0, alu_op}, {25'd0, ALU_ADD});
        check("rst_alu_first", {31'd0, alu_first}, 32'd1);
        rst = 1'b0;
        step();

        run_op("add", ALU_ADD, 32'd5, 32'd7, 32'd0, 32'h0000000C, 2);
        check("add_c1_first", {31'd0, c1_first}, 32'd1);
        run_op("sub", ALU_SUB, 32'd5, 32'd7, 32'd0, 32'hFFFFFFFE, 2);
        run_op("ltu", ALU_LTU, 32'd1, 32'hFFFFFFFF, 32'd0, 32'h00000001, 2);
        run_op("rol1", ALU_ROL, 32'h80000001, 32'd1, 32'd0, 32'h00000003, 3);
        check("rol1_c2_first", {31'd0, c2_first}, 32'd0);
        run_op("ror4", ALU_ROR, 32'h00000001, 32'd4, 32'd0, 32'h10000000, 3);
        run_op("rol0", ALU_ROL, 32'h80000001, 32'd0, 32'd0, 32'h80000001, 3);
        run_op("fsl8", ALU_FSL, 32'h12345678, 32'd8, 32'h9ABCDEF0, 32'h3456789A, 3);
        run_op("fsl32", ALU_FSL, 32'h12345678, 32'd32, 32'h9ABCDEF0, 32'h9ABCDEF0, 3);
        run_op("fsl0", ALU_FSL, 32'h12345678, 32'd0, 32'h9ABCDEF0, 32'h12345678, 3);
        run_op("cmix", ALU_CMIX, 32'hFFFF0000, 32'h00FF00FF, 32'h12345678, 32'h12FF5600, 3);
        check("cmix_c2_opb", c2_opb, 32'hFF00FF00);
        run_op("fsr8", ALU_FSR, 32'h12345678, 32'd8, 32'h9ABCDEF0, 32'hF0123456, 3);

        // Kill during EXEC2 of a rotate: result register keeps the previous value.
        issue(ALU_ROL, 32'h0000000F, 32'd4, 32'd0);
        step();
        bus.kill = 1'b1;
        step();
        bus.kill = 1'b0;
        check("kill_busy", {31'd0, bus.busy}, 32'd0);
        check("kill_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("kill_result", bus.result, 32'hF0123456);
        run_op("kill_add", ALU_ADD, 32'd1, 32'd1, 32'd0, 32'd2, 2);

        // Kill while idle blocks a same-cycle request.
        bus.kill     = 1'b1;
        bus.in_valid = 1'b1;
        bus.operator = ALU_ADD;
        step();
        bus.kill     = 1'b0;
        bus.in_valid = 1'b0;
        check("idle_kill_busy", {31'd0, bus.busy}, 32'd0);

        // Reset during EXEC1.
        issue(ALU_ROR, 32'h00000001, 32'd4, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst1_busy", {31'd0, bus.busy}, 32'd0);
        check("rst1_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst1_result", bus.result, 32'd0);
        run_op("rst1_add", ALU_ADD, 32'd1, 32'd1, 32'd0, 32'd2, 2);

        // Backpressure: hold DONE for five cycles with a second request waiting.
        bus.out_ready = 1'b0;
        issue(ALU_ADD, 32'd3, 32'd4, 32'd0);
        step();
        bus.in_valid = 1'b1;
        bus.operator = ALU_ADD;
        bus.rs1      = 32'd10;
        bus.rs2      = 32'd20;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_result", bus.result, 32'd7);
            check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        check("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
        check("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid = 1'b0;
        check("bp_second_busy", {31'd0, bus.busy}, 32'd1);
        step();
        check("bp_second_valid", {31'd0, bus.out_valid}, 32'd1);
        check("bp_second_result", bus.result, 32'd30);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ibex_alu_seq.md
Name: ibex_alu_seq

Overview:
- Upstream sequencer for `ibex_alu`. It accepts one ALU request at a time and drives the ALU operator, operand and first-cycle inputs. It returns a registered result through a valid/ready handshake.
- Base ops pass through in one execute cycle.
- The RV32B ternary and rotate ops (ROL, ROR, FSL, FSR, CMIX) are decomposed into two base-op ALU cycles (SLL/SRL/AND) and OR-combined in a local intermediate register.
- The ALU therefore never needs to produce `multicycle_result` itself.

Parameters:
RV32B, ibex_pkg::RV32BNone, bitmanip config. When RV32BNone, ROL/ROR/FSL/FSR/CMIX are treated as single-cycle pass-through.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
in_valid_i  in  1  request valid
in_ready_o  out  1  request accepted when in_valid_i & in_ready_o
operator_i  in  ibex_pkg::alu_op_e  requested operation
rs1_i  in  32  operand 1
rs2_i  in  32  operand 2 / shift amount / CMIX mask
rs3_i  in  32  operand 3 (FSL/FSR/CMIX)
kill_i  in  1  abort in-flight request
out_valid_o  out  1  result valid
out_ready_i  in  1  result consumed when out_valid_o & out_ready_i
result_o  out  32  final result
busy_o  out  1  state != IDLE
alu_operator_o  out  ibex_pkg::alu_op_e  to ALU
alu_operand_a_o  out  32  to ALU
alu_operand_b_o  out  32  to ALU
alu_instr_first_cycle_o  out  1  to ALU
alu_result_i  in  32  from ALU (combinational)

Behaviour:
- Reset (clk_i rising, rst_i=1): state=IDLE; out_valid_o=0; result_o=0; in_ready_o=1; busy_o=0; internal op/operand/imd regs=0. Reset has priority over kill_i and all handshakes.
- ALU outputs outside EXEC1/EXEC2: alu_operator_o=ALU_ADD, operands 0, alu_instr_first_cycle_o=1.
- alu_instr_first_cycle_o is 1 in EXEC1 and 0 in EXEC2; base ops ignore it.
- FSM states: IDLE, EXEC1, EXEC2, DONE.
- IDLE:
  - in_ready_o=1.
  - On acceptance, latch operator and rs1..rs3 and compute decode, then go to EXEC1.
  - in_ready_o=0 in every other state (no pipelining).
- Decode: amt=rs2[5:0] for funnel ops, rs2[4:0] for rotates.
  - Funnel ops: if amt[5]=1, swap A/B (A=rs3, B=rs1), else A=rs1, B=rs3. Then n=amt[4:0].
  - Rotates: A=B=rs1, n=rs2[4:0].
  - m=(32-n)[4:0].
- EXEC1 drives the ALU as follows:
  - ROL/FSL: ALU_SLL(A,n).
  - ROR/FSR: ALU_SRL(A,n).
  - CMIX: ALU_AND(rs1,rs2).
  - Single-cycle ops: latched operator(rs1,rs2); capture alu_result_i into result_o, then go to DONE.
  - Multicycle ops: imd<=alu_result_i, then go to EXEC2.
- EXEC2 drives the ALU as follows:
  - ROL/FSL: ALU_SRL(B,m).
  - ROR/FSR: ALU_SLL(B,m).
  - CMIX: ALU_AND(rs3,~rs2).
  - Result is result_o<=imd|alu_result_i, except when n==0 on rotate/funnel ops: result_o<=A (covers funnel amt 0 -> rs1, amt 32 -> rs3).
  - Then go to DONE.
- DONE:
  - out_valid_o=1; result_o stable.
  - On out_ready_i go to IDLE, out_valid_o=0 next cycle.
  - A new request is accepted no earlier than the cycle after return to IDLE.
- Latency (acceptance edge T): single-cycle out_valid_o high from T+2; multicycle from T+3. Throughput is one request per 3 (4) cycles minimum.
- kill_i in EXEC1/EXEC2/DONE: next state IDLE, out_valid_o=0, imd cleared, result discarded. kill_i in IDLE: no effect, and a same-cycle in_valid_i is not accepted.
- Comparison ops return alu_result_i as-is ({31'b0, cmp}).
- Operand widths: all 32 bit; m wraps modulo 32; no arithmetic beyond 5-bit subtract.

Test Plan:
- ADD rs1=5, rs2=7, out_ready_i=1 -> result_o=0x0000000C, out_valid_o first high 2 cycles after acceptance, single pulse.
- ROL rs1=0x80000001 rs2=1 -> 0x00000003 at T+3; ROR rs1=0x00000001 rs2=4 -> 0x10000000; ROL rs2=0 -> 0x80000001.
- FSL rs1=0x12345678 rs3=0x9ABCDEF0 rs2=8 -> 0x3456789A; same operands rs2=32 -> 0x9ABCDEF0, rs2=0 -> 0x12345678; FSR rs2=8 -> 0xF0123456.
- CMIX rs1=0xFFFF0000 rs2=0x00FF00FF rs3=0x12345678 -> 0x12FF5600; alu_operand_b_o=0xFF00FF00 in EXEC2.
- Backpressure: hold out_ready_i=0 for 5 cycles in DONE -> out_valid_o and result_o stable, in_ready_o=0, second in_valid_i not accepted until after handshake.
- kill_i asserted in EXEC2 of ROL, and separately rst_i in EXEC1 -> next cycle IDLE, out_valid_o=0, result_o unchanged (kill) / 0 (reset), next ADD 1+1 returns 2.
